// File: rtl/sram_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sram_arb_pkg                                               |
// | Brief    : Shared widths and response-id encoding for the SRAM        |
// |            port arbiter.                                              |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package sram_arb_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = 4;

  // Which requester owns the response in flight on port 0
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_M0   = 2'd1,
    RESP_M1   = 2'd2
  } resp_id_t;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sram_port_arbiter_if                                       |
// | Brief    : Requester-side bundle: two port-0 masters (m0, m1) and     |
// |            the fetch requester (f).                                   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_arb_pkg::NUM_WMASKS
);

  logic                  m0_valid;
  logic                  m0_ready;
  logic                  m0_we;
  logic [NUM_WMASKS-1:0] m0_wmask;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_valid;
  logic                  m1_ready;
  logic                  m1_we;
  logic [NUM_WMASKS-1:0] m1_wmask;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  f_valid;
  logic                  f_ready;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;

  // Requester side
  modport master (
    output m0_valid, m0_we, m0_wmask, m0_addr, m0_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_valid, m1_we, m1_wmask, m1_addr, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    output f_valid, f_addr,
    input  f_ready, f_rvalid, f_rdata
  );

  // Arbiter side
  modport slave (
    input  m0_valid, m0_we, m0_wmask, m0_addr, m0_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_valid, m1_we, m1_wmask, m1_addr, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    input  f_valid, f_addr,
    output f_ready, f_rvalid, f_rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : rr_arb2                                                    |
// | Brief    : Two-way round-robin grant with fixed-priority override     |
// |            for requester 0. Grant is combinational and one-hot.       |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] req,
  input  wire logic       pri_override,
  input  wire logic       advance,
  output logic      [1:0] gnt
);

  // 1 = requester 1 won the last accepted arbitration
  logic last_grant;

  // Tie goes to requester 0 under override, otherwise to whoever lost last time
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (pri_override || last_grant) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner only when the grant was actually taken; reset favours m0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sram_port_arbiter                                          |
// | Brief    : Front-end for a 1RW + 1R SRAM macro. Arbitrates m0/m1 onto |
// |            port 0, serves fetch on port 1, stalls a fetch colliding   |
// |            with a same-cycle write, returns responses one cycle later.|
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_arb_pkg::NUM_WMASKS
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  host_pri,
  sram_port_arbiter_if.slave         bus,
  output logic                       csb0,
  output logic                       web0,
  output logic      [NUM_WMASKS-1:0] wmask0,
  output logic      [ADDR_WIDTH-1:0] addr0,
  output logic      [DATA_WIDTH-1:0] din0,
  input  wire logic [DATA_WIDTH-1:0] dout0,
  output logic                       csb1,
  output logic      [ADDR_WIDTH-1:0] addr1,
  input  wire logic [DATA_WIDTH-1:0] dout1
);

  import sram_arb_pkg::*;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       collision;
  logic       f_accept;
  resp_id_t   resp_id;
  logic       resp_is_read;
  logic       f_pend;

  // Requests are masked while in reset so nothing is granted or accepted
  assign req = {bus.m1_valid, bus.m0_valid} & {2{rst_n}};

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .pri_override (host_pri),
    .advance      (|gnt),
    .gnt          (gnt)
  );

  assign bus.m0_ready = gnt[0];
  assign bus.m1_ready = gnt[1];

  // Steer the winner onto port 0; idle values when nobody is granted
  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (gnt[0]) begin
      csb0   = 1'b0;
      web0   = ~bus.m0_we;
      wmask0 = bus.m0_we ? bus.m0_wmask : '0;
      addr0  = bus.m0_addr;
      din0   = bus.m0_wdata;
    end else if (gnt[1]) begin
      csb0   = 1'b0;
      web0   = ~bus.m1_we;
      wmask0 = bus.m1_we ? bus.m1_wmask : '0;
      addr0  = bus.m1_addr;
      din0   = bus.m1_wdata;
    end
  end

  // A fetch of the word being written this cycle waits one cycle so it sees the new data
  always_comb begin
    collision = !csb0 && !web0 && (addr0 == bus.f_addr);
    f_accept  = rst_n && bus.f_valid && !collision;
    csb1      = ~f_accept;
    addr1     = f_accept ? bus.f_addr : '0;
  end

  assign bus.f_ready = f_accept;

  // Track who owns next cycle's response; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_id      <= RESP_NONE;
      resp_is_read <= 1'b0;
      f_pend       <= 1'b0;
    end else begin
      resp_id      <= gnt[0] ? RESP_M0 : (gnt[1] ? RESP_M1 : RESP_NONE);
      resp_is_read <= web0;
      f_pend       <= f_accept;
    end
  end

  // Responses are gated by rst_n so a reset cycle never shows a stale rvalid
  always_comb begin
    bus.m0_rvalid = rst_n && (resp_id == RESP_M0);
    bus.m1_rvalid = rst_n && (resp_id == RESP_M1);
    bus.f_rvalid  = rst_n && f_pend;
    bus.m0_rdata  = (bus.m0_rvalid && resp_is_read) ? dout0 : '0;
    bus.m1_rdata  = (bus.m1_rvalid && resp_is_read) ? dout0 : '0;
    bus.f_rdata   = bus.f_rvalid ? dout1 : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_sram_port_arbiter                                       |
// | Brief    : Directed bench with an SRAM behavioural model and per-     |
// |            requester response queues for sram_port_arbiter.           |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_sram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_pri;
  logic          csb0, web0, csb1;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, dout0, dout1;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host_pri (host_pri),
    .bus      (bus),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .csb1     (csb1),
    .addr1    (addr1),
    .dout1    (dout1)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A000000 ^ (i * 32'h00010203);
  endfunction

  // SRAM macro model: latch at posedge, write and drive dout at negedge
  logic [DW-1:0] mem [512];
  logic          mem_init_done = 1'b0;
  logic          l0_cs, l0_we, l1_cs;
  logic [MW-1:0] l0_mask;
  logic [AW-1:0] l0_addr, l1_addr;
  logic [DW-1:0] l0_din;

  always @(posedge clk) begin
    l0_cs   <= !csb0;
    l0_we   <= !web0;
    l0_mask <= wmask0;
    l0_addr <= addr0;
    l0_din  <= din0;
    l1_cs   <= !csb1;
    l1_addr <= addr1;
  end

  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else begin
      if (l0_cs && l0_we) begin
        for (int b = 0; b < MW; b++)
          if (l0_mask[b]) mem[l0_addr][8*b +: 8] <= l0_din[8*b +: 8];
      end else if (l0_cs) begin
        dout0 <= mem[l0_addr];
      end
      if (l1_cs) dout1 <= mem[l1_addr];
    end
  end

  // Bench-side reference memory and scoreboard
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] q_m0 [$];
  logic [DW-1:0] q_m1 [$];
  logic [DW-1:0] q_f  [$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
    for (int b = 0; b < MW; b++)
      if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic set_m0(input logic v, input logic we, input logic [MW-1:0] m,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m0_valid = v; bus.m0_we = we; bus.m0_wmask = m; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input logic v, input logic we, input logic [MW-1:0] m,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m1_valid = v; bus.m1_we = we; bus.m1_wmask = m; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  task automatic set_f(input logic v, input logic [AW-1:0] a);
    bus.f_valid = v; bus.f_addr = a;
  endtask

  // One cycle: check readies and port pins, queue expected responses,
  // cross the edge, then check the responses due this cycle.
  task automatic tick(input logic e0, input logic e1, input logic ef);
    logic          x_web;
    logic [MW-1:0] x_wm;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_din;
    x_web = 1'b1; x_wm = '0; x_addr = '0; x_din = '0;
    #1;
    check("m0_ready", bus.m0_ready, e0);
    check("m1_ready", bus.m1_ready, e1);
    check("f_ready",  bus.f_ready,  ef);
    check("csb0", csb0, !(e0 || e1));
    check("csb1", csb1, !ef);
    if (e0) begin
      x_web = !bus.m0_we; x_wm = bus.m0_we ? bus.m0_wmask : '0;
      x_addr = bus.m0_addr; x_din = bus.m0_wdata;
    end else if (e1) begin
      x_web = !bus.m1_we; x_wm = bus.m1_we ? bus.m1_wmask : '0;
      x_addr = bus.m1_addr; x_din = bus.m1_wdata;
    end
    check("web0",   web0,   x_web);
    check("wmask0", wmask0, x_wm);
    check("addr0",  addr0,  x_addr);
    check("din0",   din0,   x_din);
    check("addr1",  addr1,  ef ? bus.f_addr : '0);
    if (ef) q_f.push_back(ref_mem[bus.f_addr]);
    if (e0) begin
      q_m0.push_back(bus.m0_we ? '0 : ref_mem[bus.m0_addr]);
      if (bus.m0_we) ref_write(bus.m0_addr, bus.m0_wmask, bus.m0_wdata);
    end
    if (e1) begin
      q_m1.push_back(bus.m1_we ? '0 : ref_mem[bus.m1_addr]);
      if (bus.m1_we) ref_write(bus.m1_addr, bus.m1_wmask, bus.m1_wdata);
    end
    @(posedge clk);
    #6;
    check("m0_rvalid", bus.m0_rvalid, q_m0.size() != 0);
    check("m0_rdata",  bus.m0_rdata,  (q_m0.size() != 0) ? q_m0.pop_front() : '0);
    check("m1_rvalid", bus.m1_rvalid, q_m1.size() != 0);
    check("m1_rdata",  bus.m1_rdata,  (q_m1.size() != 0) ? q_m1.pop_front() : '0);
    check("f_rvalid",  bus.f_rvalid,  q_f.size() != 0);
    check("f_rdata",   bus.f_rdata,   (q_f.size() != 0) ? q_f.pop_front() : '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    host_pri = 1'b0;
    set_m0(1'b1, 1'b1, 4'hF, 9'h003, 32'h11111111);
    set_m1(1'b1, 1'b0, 4'h0, 9'h004, 32'h0);
    set_f(1'b1, 9'h006);

    // Held in reset with every requester valid: everything must stay idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_ready", bus.m0_ready, 1'b0);
    check("rst_m1_ready", bus.m1_ready, 1'b0);
    check("rst_f_ready",  bus.f_ready,  1'b0);
    check("rst_csb0",     csb0,   1'b1);
    check("rst_csb1",     csb1,   1'b1);
    check("rst_web0",     web0,   1'b1);
    check("rst_wmask0",   wmask0, 4'h0);
    check("rst_addr0",    addr0,  9'h0);
    check("rst_din0",     din0,   32'h0);
    check("rst_addr1",    addr1,  9'h0);
    check("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    check("rst_f_rvalid",  bus.f_rvalid,  1'b0);
    check("rst_m0_rdata",  bus.m0_rdata,  32'h0);

    #5;
    rst_n = 1'b1;
    set_m0(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    set_f(1'b0, 9'h0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);

    // Response in flight when reset asserts is dropped
    set_m1(1'b1, 1'b0, 4'h0, 9'h007, 32'h0);
    #1;
    check("drop_m1_ready", bus.m1_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    #5;
    check("drop_m1_rvalid_rst", bus.m1_rvalid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #5;
    check("drop_m1_rvalid_after", bus.m1_rvalid, 1'b0);

    // Round-robin tie: first tie after reset goes to m0
    host_pri = 1'b0;
    set_m0(1'b1, 1'b0, 4'h0, 9'h001, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 9'h002, 32'h0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // Host priority: m0 wins every tie
    host_pri = 1'b1;
    repeat (4) tick(1'b1, 1'b0, 1'b0);

    // Full write then m1 read of the same word
    set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    set_m0(1'b1, 1'b1, 4'b1111, 9'h005, 32'hDEADBEEF);
    tick(1'b1, 1'b0, 1'b0);
    set_m0(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
    tick(1'b0, 1'b1, 1'b0);
    set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    tick(1'b0, 1'b0, 1'b0);

    // Byte-lane write then read back
    set_m0(1'b1, 1'b1, 4'b0010, 9'h005, 32'h0000AB00);
    tick(1'b1, 1'b0, 1'b0);
    set_m0(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
    tick(1'b1, 1'b0, 1'b0);
    set_m0(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    check("masked_ref", ref_mem[9'h005], 32'hDEADABEF);

    // Write/fetch collision stalls the fetch, which then sees the new data
    set_m1(1'b1, 1'b1, 4'hF, 9'h1FF, 32'h12345678);
    set_f(1'b1, 9'h1FF);
    tick(1'b0, 1'b1, 1'b0);
    set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    // Same-address read plus fetch is not a collision
    set_m1(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
    tick(1'b0, 1'b1, 1'b1);
    // Write to a different address does not stall the fetch
    set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    set_m0(1'b1, 1'b1, 4'hF, 9'h010, 32'hCAFEF00D);
    set_f(1'b1, 9'h011);
    tick(1'b1, 1'b0, 1'b1);
    set_m0(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);

    // Back-to-back fetch stream with port 0 idle
    for (int i = 0; i < 8; i++) begin
      set_f(1'b1, 9'(i));
      tick(1'b0, 1'b0, 1'b1);
    end
    set_f(1'b0, 9'h0);
    tick(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
